// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : seg7_pkg                                                      |
// | Description: Shared constants for the seven-segment scanner: the width of  |
// |              the brightness phase counter and the 16-entry hex glyph table |
// |              (active-high, bit 0 = segment a ... bit 6 = segment g).       |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package seg7_pkg;

  // Sixteen phases per digit slot, one per brightness step.
  localparam int PHASE_W = 4;

  // Standard hex glyphs, index = nibble value.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : seg7_decode                                                   |
// | Description: Combinational nibble-to-segment decoder, active-high output.  |
// |              Output polarity is applied by the instantiating scanner.      |
// | Ports      : nib_i  [3:0]  hex nibble                                      |
// |              seg_o  [6:0]  segments a..g, bit 0 = a, 1 = segment on        |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_GLYPH[nib_i];

endmodule : seg7_decode
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : seg7_scan                                                     |
// | Description: Multiplexed seven-segment display scanner with per-slot PWM   |
// |              brightness and frame-synchronous double buffering of the      |
// |              displayed data. Optional leading-zero blanking is built when  |
// |              the macro SEG7_SCAN_LZB_EN is defined.                        |
// | Ports      : clk     rising-edge clock                                     |
// |              rst_n   synchronous active-low reset                          |
// |              data    [4*NUM_DIGITS-1:0] nibble i feeds digit i             |
// |              dp_in   [NUM_DIGITS-1:0]   decimal point per digit            |
// |              load    single-cycle capture strobe for data/dp_in            |
// |              bright  [3:0] on-time per slot in 16ths, 0 = dark             |
// |              led     [6:0] segments a..g (bit 0 = a)                       |
// |              dp      decimal point segment                                 |
// |              dig     [NUM_DIGITS-1:0] digit enables                        |
// |              frame   one-cycle pulse when the scan wraps to digit 0        |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [3:0]              bright,
  output logic [6:0]              led,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame
);

  localparam int TICKS  = PRESCALE / 16;
  localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = '1;
  // XOR mask that turns active-high internal values into the pin polarity.
  localparam logic               POL        = (ACTIVE_LOW != 0);

  // Scan counters
  logic [TICK_W-1:0]       tick_q,  tick_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [IDX_W-1:0]        idx_q,   idx_d;

  // Double buffer: pending collects loads, active feeds the display
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q,   pend_dp_d;
  logic [4*NUM_DIGITS-1:0] act_data_q,  act_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q,    act_dp_d;

  // Registered outputs
  logic [6:0]              led_q,   led_d;
  logic                    dp_q,    dp_d;
  logic [NUM_DIGITS-1:0]   dig_q,   dig_d;
  logic                    frame_q, frame_d;

  logic                    tick_wrap;
  logic                    phase_wrap;
  logic                    idx_wrap;

  // --------------------------------------------------------------------------
  // Counter and buffer next-state
  // --------------------------------------------------------------------------
  always_comb begin
    tick_wrap  = (tick_q == TICK_LAST);
    phase_wrap = tick_wrap && (phase_q == PHASE_LAST);
    idx_wrap   = phase_wrap && (idx_q == IDX_LAST);

    tick_d  = tick_wrap ? '0 : tick_q + 1'b1;
    // Phase is exactly PHASE_W bits wide, so 15 + 1 rolls over to 0.
    phase_d = tick_wrap ? phase_q + 1'b1 : phase_q;
    idx_d   = idx_q;
    if (phase_wrap) begin
      idx_d = idx_wrap ? '0 : idx_q + 1'b1;
    end

    pend_data_d = load ? data  : pend_data_q;
    pend_dp_d   = load ? dp_in : pend_dp_q;

    // Active only changes on the frame boundary, so a frame is never mixed.
    // A load on the boundary itself goes straight to active.
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    if (idx_wrap) begin
      act_data_d = load ? data  : pend_data_q;
      act_dp_d   = load ? dp_in : pend_dp_q;
    end

    frame_d = idx_wrap;
  end

  // --------------------------------------------------------------------------
  // Per-digit enable (leading-zero blanking)
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] digit_en;

`ifdef SEG7_SCAN_LZB_EN
  // A digit is blanked while every nibble from the top down to it is zero.
  // Digit 0 is outside the loop and therefore never blanked.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    digit_en = '1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (act_data_q[4*i +: 4] == 4'h0);
      digit_en[i] = !zero_run;
    end
  end
`else
  assign digit_en = '1;
`endif

  // --------------------------------------------------------------------------
  // Digit selection and output next-state
  // --------------------------------------------------------------------------
  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic [NUM_DIGITS-1:0] dig_hi;
  logic [6:0]            seg_hi;
  logic                  show;
  logic                  lit;

  always_comb begin
    show    = (phase_q < bright);
    sel_nib = 4'h0;
    sel_dp  = 1'b0;
    dig_hi  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nib   = act_data_q[4*i +: 4];
        sel_dp    = act_dp_q[i];
        dig_hi[i] = show && digit_en[i];
      end
    end
  end

  seg7_decode u_decode (
    .nib_i (sel_nib),
    .seg_o (seg_hi)
  );

  always_comb begin
    lit   = |dig_hi;
    led_d = (lit ? seg_hi : 7'h00) ^ {7{POL}};
    dp_d  = (lit & sel_dp) ^ POL;
    dig_d = dig_hi ^ {NUM_DIGITS{POL}};
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q      <= '0;
      phase_q     <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      led_q       <= {7{POL}};
      dp_q        <= POL;
      dig_q       <= {NUM_DIGITS{POL}};
      frame_q     <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      led_q       <= led_d;
      dp_q        <= dp_d;
      dig_q       <= dig_d;
      frame_q     <= frame_d;
    end
  end

  assign led   = led_q;
  assign dp    = dp_q;
  assign dig   = dig_q;
  assign frame = frame_q;

endmodule : seg7_scan
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_seg7_scan                                                  |
// | Description: Self-checking bench for seg7_scan (4 digits, PRESCALE 16,     |
// |              active-low). Stimulus queues one expected frame image per     |
// |              frame of interest; the monitor aligns on the frame pulse and  |
// |              compares all 64 cycles of that frame, digit by digit.         |
// |              Follows SEG7_SCAN_LZB_EN for the blanking expectations.       |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  bright;
  logic [6:0]  led;
  logic        dp;
  logic [3:0]  dig;
  logic        frame;

  always #5 clk = ~clk;

  seg7_scan #(
    .NUM_DIGITS (4),
    .PRESCALE   (16),
    .ACTIVE_LOW (1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .dp_in  (dp_in),
    .load   (load),
    .bright (bright),
    .led    (led),
    .dp     (dp),
    .dig    (dig),
    .frame  (frame)
  );

  // Active-low glyphs, hand-derived: 0 = segment on.
  localparam logic [6:0] GLY_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    int          fno;   // frame number after the most recent reset
    logic [27:0] led;   // expected active-low glyph per digit (7 bits each)
    logic [3:0]  dp;    // dp request per digit (1 = on)
    logic [19:0] lit;   // lit cycles per slot per digit (5 bits each)
  } exp_t;

  exp_t q[$];
  int   checks      = 0;
  int   errors      = 0;
  int   fno         = 0;
  int   pushed      = 0;
  int   done_frames = 0;
  int   rst_cnt     = 0;

  always @(posedge clk) if (!rst_n) rst_cnt <= rst_cnt + 1;

  function automatic exp_t mk(input int n, input logic [15:0] d,
                              input logic [3:0] p, input logic [3:0] br);
    exp_t       e;
    logic [3:0] nb;
    logic       zr;
    e     = '0;
    e.fno = n;
    e.dp  = p;
    zr    = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      nb = d[4*k +: 4];
      e.led[7*k +: 7] = GLY_AL[nb];
      zr = zr && (nb == 4'h0);
`ifdef SEG7_SCAN_LZB_EN
      if (k > 0 && zr) e.lit[5*k +: 5] = 5'd0;
      else             e.lit[5*k +: 5] = {1'b0, br};
`else
      e.lit[5*k +: 5] = {1'b0, br};
`endif
    end
    return e;
  endfunction

  task automatic push_exp(input int n, input logic [15:0] d,
                          input logic [3:0] p, input logic [3:0] br);
    q.push_back(mk(n, d, p, br));
    pushed++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    data  = d;
    dp_in = p;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  // Returns 1 ns after the first rising edge following frame pulse n.
  task automatic wait_frame(input int n);
    int t;
    t = 0;
    while (fno < n && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (fno < n) begin
      checks++;
      errors++;
      $display("FAIL wait_frame%0d: got frame count %0d expected %0d", n, fno, n);
    end
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  initial begin : mon
    exp_t       e;
    int         last_rst;
    int         dgt, ph, lim;
    logic       on, bad;
    logic [3:0] xdig, bdig_a, bdig_x;
    logic [6:0] xled, bled_a, bled_x;
    logic       xdp, xfr, bdp_a, bdp_x, bfr_a, bfr_x;
    int         bcyc;
    last_rst = 0;
    forever begin
      @(negedge clk);
      if (rst_cnt != last_rst) begin
        last_rst = rst_cnt;
        fno      = 0;
      end else if (frame === 1'b1) begin
        fno++;
        while (q.size() > 0 && q[0].fno < fno) begin
          checks++;
          errors++;
          $display("FAIL frame%0d: got no aligned frame pulse expected one", q[0].fno);
          void'(q.pop_front());
        end
        while (q.size() > 0 && q[0].fno == fno) begin
          e = q.pop_front();
          bad = 1'b0;
          {bdig_a, bdig_x, bled_a, bled_x, bdp_a, bdp_x, bfr_a, bfr_x} = '0;
          bcyc = 0;
          for (int s = 0; s < 64; s++) begin
            @(negedge clk);
            dgt  = s / 16;
            ph   = s % 16;
            lim  = int'(e.lit[5*dgt +: 5]);
            on   = (ph < lim);
            xdig = on ? ~(4'b0001 << dgt) : 4'hF;
            xled = on ? e.led[7*dgt +: 7] : 7'h7F;
            xdp  = on ? ~e.dp[dgt] : 1'b1;
            xfr  = (s == 63);
            if (ph == 0) bad = 1'b0;
            if (!bad && ({dig, led, dp, frame} !== {xdig, xled, xdp, xfr})) begin
              bad = 1'b1;
              bcyc = ph;
              {bdig_a, bled_a, bdp_a, bfr_a} = {dig, led, dp, frame};
              {bdig_x, bled_x, bdp_x, bfr_x} = {xdig, xled, xdp, xfr};
            end
            if (ph == 15) begin
              checks++;
              if (bad) begin
                errors++;
                $display("FAIL frame%0d digit%0d cycle%0d: got dig=%b led=%h dp=%b frame=%b expected dig=%b led=%h dp=%b frame=%b",
                         e.fno, dgt, bcyc, bdig_a, bled_a, bdp_a, bfr_a, bdig_x, bled_x, bdp_x, bfr_x);
              end
            end
          end
          done_frames++;
          if (frame === 1'b1) fno++;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : stim
    int t;
    rst_n  = 1'b0;
    load   = 1'b1;          // must be ignored while in reset
    data   = 16'hFFFF;
    dp_in  = 4'hF;
    bright = 4'd15;
    step(3);
    @(negedge clk);
    chk("rst_dig",   {28'd0, dig},   32'hF);
    chk("rst_led",   {25'd0, led},   32'h7F);
    chk("rst_dp",    {31'd0, dp},    32'h1);
    chk("rst_frame", {31'd0, frame}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load  = 1'b0;
    data  = 16'h0000;
    dp_in = 4'h0;

    push_exp(1, 16'h1234, 4'b0000, 4'd15);   // 4,3,2,1 lit 15 of 16
    push_exp(2, 16'h1234, 4'b0101, 4'd4);    // 4 cycles per slot, dp on 0 and 2
    push_exp(3, 16'h1234, 4'b0101, 4'd0);    // dark
    push_exp(4, 16'h1234, 4'b0101, 4'd15);   // AAAA/5555 loaded here stay hidden
    push_exp(5, 16'h5555, 4'b0000, 4'd15);   // last load of frame 4 wins
    push_exp(6, 16'h9876, 4'b1000, 4'd15);   // load on the wrap edge bypasses pending

    pulse_load(16'h1234, 4'b0000);
    wait_frame(1);                           // E1+1
    step(9);                                 // E1+10
    pulse_load(16'h1234, 4'b0101);           // captured at E1+11
    step(53);                                // E2
    bright = 4'd4;
    step(64);                                // E3
    bright = 4'd0;
    step(64);                                // E4
    bright = 4'd15;
    step(20);                                // E4+20
    pulse_load(16'hAAAA, 4'b0000);           // E4+21
    step(10);                                // E4+31
    pulse_load(16'h5555, 4'b0000);           // E4+32
    step(95);                                // E5+63
    pulse_load(16'h9876, 4'b1000);           // captured on the E6 wrap edge
    step(64);                                // E7
    step(5);
    pulse_load(16'h7777, 4'hF);              // pending only, discarded by reset
    step(14);                                // E7+20, mid-slot

    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_dig",   {28'd0, dig},   32'hF);
    chk("midrst_frame", {31'd0, frame}, 32'h0);
    chk("midrst_led",   {25'd0, led},   32'h7F);
    chk("midrst_dp",    {31'd0, dp},    32'h1);
    @(negedge clk);
    chk("restart_dig", {28'd0, dig}, 32'hE);
    chk("restart_led", {25'd0, led}, 32'h40);
    chk("restart_dp",  {31'd0, dp},  32'h1);
    @(posedge clk);
    #1;

    push_exp(1, 16'h0000, 4'b0000, 4'd15);   // cleared buffers show zeros
    push_exp(2, 16'h0050, 4'b0000, 4'd15);
    push_exp(3, 16'h0000, 4'b0001, 4'd15);
    wait_frame(1);
    step(9);
    pulse_load(16'h0050, 4'b0000);           // E1+11
    step(53);                                // E2
    step(10);
    pulse_load(16'h0000, 4'b0001);           // E2+11

    t = 0;
    while (done_frames < pushed && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (done_frames < pushed) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d frames checked expected %0d", done_frames, pushed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seg7_scan
`default_nettype wire
